stack_arbiter: RTL
==================

STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, 4, stack word width.
REQ-002 SHALL have parameter DEPTH, 8, stack capacity in words.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port Clk  input  1  rising-edge clock.
REQ-005 SHALL have port Reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port ReqA/ReqB  input  1  operation request, held until DoneX.
REQ-007 SHALL have port OpA/OpB  input  1  0=push, 1=pop, stable while ReqX.
REQ-008 SHALL have port WDataA/WDataB  input  DATA_W  push data, stable while ReqX.
REQ-009 SHALL have port GntA/GntB  output  1  one-cycle pulse on acceptance.
REQ-010 SHALL have port DoneA/DoneB  output  1  one-cycle completion pulse.
REQ-011 SHALL have port ErrA/ErrB  output  1  valid with DoneX; operation refused or failed.
REQ-012 SHALL have port RDataA/RDataB  output  DATA_W  popped word, valid from DoneX until next pop by same requester.
REQ-013 SHALL have port StkReset/StkPush/StkPop  output  1  stack control strobes.
REQ-014 SHALL have port StkDataIO  inout  DATA_W  stack data bus, driven only in push states, else high-Z.
REQ-015 SHALL have port StkErr  input  1  stack error flag.
REQ-016 SHALL have port Count  output  $clog2(DEPTH+1)  words held.

Function
REQ-017 SHALL implement FSM states IDLE, PUSH_DRV, PUSH_STB, PUSH_END, POP_STB, POP_CAP, POP_END, REFUSE.
REQ-018 SHALL sample ReqA/ReqB only in IDLE; winner latched with Op/WData, GntX pulsed that cycle.
REQ-019 SHALL route push with Count<DEPTH: IDLE->PUSH_DRV (bus driven, StkPush=0)->PUSH_STB (StkPush=1)->PUSH_END (StkPush=0, bus held, DoneX, Count+1)->IDLE.
REQ-020 SHALL route pop with Count>0: IDLE->POP_STB (StkPop=1)->POP_CAP (StkPop=1, RDataX<=StkDataIO)->POP_END (StkPop=0, DoneX, Count-1)->IDLE.
REQ-021 SHALL route push at Count==DEPTH or pop at Count==0 to REFUSE: DoneX=1, ErrX=1, no strobe, Count unchanged.
REQ-022 SHALL raise ErrX with DoneX if StkErr is high in PUSH_END/POP_END; Count still updates.
REQ-023 SHALL give latency Gnt->Done of 3 cycles for push/pop, 1 cycle for refused.
REQ-024 SHALL never assert StkPush and StkPop together; at most one operation in flight.
REQ-025 SHALL treat ReqX still high in the IDLE cycle after DoneX as a new request.
REQ-026 SHALL keep Count in 0..DEPTH; no wrap.

Reset
REQ-027 SHALL on Reset: state IDLE, Count=0, Gnt/Done/Err=0, RDataA/B=0, StkPush/StkPop=0, bus high-Z, RR pointer=B.
REQ-028 SHALL drive StkReset as a registered copy of Reset (one cycle delayed, same length).
REQ-029 SHALL abort an in-flight operation on Reset with no DoneX.

Configuration
REQ-030 SHALL with STACK_ARB_RR_EN defined arbitrate round-robin: on simultaneous requests serve the requester not served last; pointer updates on every grant.
REQ-031 SHALL without STACK_ARB_RR_EN give ReqA fixed priority over ReqB.

Structure
REQ-032 SHALL place DATA_W/DEPTH defaults, op encoding (OP_PUSH/OP_POP) and state enum in package stack_pkg.
REQ-033 SHALL isolate winner selection in sub-module stack_arb_pick (inputs ReqA, ReqB, pointer; output one-hot grant).

Verification
REQ-034 SHALL cover: A push 4'h5 from reset -> GntA cycle 0, StkPush high cycle 2 only, DoneA cycle 3, Count=1.
REQ-035 SHALL cover: push 4'h5, 4'hA then B pop twice -> RDataB 4'hA then 4'h5, Count=0, ErrB=0.
REQ-036 SHALL cover: pop at Count=0 -> DoneA+ErrA next cycle, no StkPop; 9 pushes -> 9th ErrX=1, Count=8.
REQ-037 SHALL cover: ReqA and ReqB held together 4 ops -> with RR grants A,B,A,B; without RR A,A,A,A.
REQ-038 SHALL cover: Reset in POP_CAP -> next cycle IDLE, StkPop=0, no Done, StkReset high one cycle delayed, Count=0.

Source files
------------

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared defaults, op encoding and FSM states for the stack arbiter
package stack_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 8;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_DRV,
    PUSH_STB,
    PUSH_END,
    POP_STB,
    POP_CAP,
    POP_END,
    REFUSE
  } stack_state_e;

endpackage

// File: rtl/stack_arb_pick.sv
// rtl/stack_arb_pick.sv - two-requester winner selection; round-robin when STACK_ARB_RR_EN is defined
module stack_arb_pick (
  input  logic       ReqA,
  input  logic       ReqB,
  input  logic       pointer,
  output logic [1:0] grant
);

`ifdef STACK_ARB_RR_EN
  // pointer names the requester served last (1 = B); on a tie the other one wins
  always_comb begin
    grant = 2'b00;
    if (ReqA && ReqB) begin
      grant = pointer ? 2'b01 : 2'b10;
    end else if (ReqA) begin
      grant = 2'b01;
    end else if (ReqB) begin
      grant = 2'b10;
    end
  end
`else
  logic pointer_unused;
  assign pointer_unused = pointer;

  always_comb begin
    grant = 2'b00;
    if (ReqA) begin
      grant = 2'b01;
    end else if (ReqB) begin
      grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - two-port arbiter driving an external stack; STACK_ARB_RR_EN selects round-robin
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       ReqA,
  input  logic                       ReqB,
  input  logic                       OpA,
  input  logic                       OpB,
  input  logic [DATA_W-1:0]          WDataA,
  input  logic [DATA_W-1:0]          WDataB,
  output logic                       GntA,
  output logic                       GntB,
  output logic                       DoneA,
  output logic                       DoneB,
  output logic                       ErrA,
  output logic                       ErrB,
  output logic [DATA_W-1:0]          RDataA,
  output logic [DATA_W-1:0]          RDataB,
  output logic                       StkReset,
  output logic                       StkPush,
  output logic                       StkPop,
  inout  wire  [DATA_W-1:0]          StkDataIO,
  input  logic                       StkErr,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  stack_state_e      state_q, state_d;
  logic              owner_q;
  logic              op_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] rdata_a_q, rdata_b_q;
  logic              stk_reset_q;
  logic [1:0]        grant;
  logic              sel_op;
  logic              done;
  logic              err;
  logic              bus_drive;

  stack_arb_pick u_pick (
    .ReqA    (ReqA),
    .ReqB    (ReqB),
    .pointer (ptr_q),
    .grant   (grant)
  );

  always_comb begin
    state_d = state_q;
    GntA    = 1'b0;
    GntB    = 1'b0;
    StkPush = 1'b0;
    StkPop  = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    sel_op  = grant[1] ? OpB : OpA;
    case (state_q)
      IDLE: begin
        // Requests are ignored while Reset is held so no grant leaks out
        if (!Reset && (grant != 2'b00)) begin
          GntA = grant[0];
          GntB = grant[1];
          if (sel_op == OP_PUSH) begin
            state_d = (count_q == FULL) ? REFUSE : PUSH_DRV;
          end else begin
            state_d = (count_q == '0) ? REFUSE : POP_STB;
          end
        end
      end
      PUSH_DRV: state_d = PUSH_STB;
      PUSH_STB: begin
        StkPush = 1'b1;
        state_d = PUSH_END;
      end
      PUSH_END: begin
        done    = 1'b1;
        err     = StkErr;
        state_d = IDLE;
      end
      POP_STB: begin
        StkPop  = 1'b1;
        state_d = POP_CAP;
      end
      POP_CAP: begin
        StkPop  = 1'b1;
        state_d = POP_END;
      end
      POP_END: begin
        done    = 1'b1;
        err     = StkErr;
        state_d = IDLE;
      end
      REFUSE: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      op_q      <= OP_POP;
      wdata_q   <= '0;
      ptr_q     <= 1'b1;
      count_q   <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q <= state_d;
      if (GntA || GntB) begin
        owner_q <= GntB;
        op_q    <= sel_op;
        wdata_q <= GntB ? WDataB : WDataA;
        ptr_q   <= GntB;
      end
      if (state_q == POP_CAP) begin
        if (owner_q) begin
          rdata_b_q <= StkDataIO;
        end else begin
          rdata_a_q <= StkDataIO;
        end
      end
      if ((state_q == PUSH_END) && (count_q != FULL)) begin
        count_q <= count_q + CNT_W'(1);
      end else if ((state_q == POP_END) && (count_q != '0)) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // StkReset follows Reset by one cycle, so it is deliberately outside the reset branch
  always_ff @(posedge Clk) begin
    stk_reset_q <= Reset;
  end

  assign bus_drive = (op_q == OP_PUSH) &&
                     ((state_q == PUSH_DRV) || (state_q == PUSH_STB) || (state_q == PUSH_END));
  assign StkDataIO = bus_drive ? wdata_q : {DATA_W{1'bz}};

  assign DoneA    = done & ~owner_q;
  assign DoneB    = done & owner_q;
  assign ErrA     = err & ~owner_q;
  assign ErrB     = err & owner_q;
  assign RDataA   = rdata_a_q;
  assign RDataB   = rdata_b_q;
  assign Count    = count_q;
  assign StkReset = stk_reset_q;

endmodule
